lcd_char_writer: RTL and testbench
==================================

// Module: lcd_char_writer
// PURPOSE
//   Drives a 16x2 HD44780-class character LCD in 8-bit write-only mode.
//   Runs the power-up/init sequence, then refreshes the display forever.
//   Each pass fetches 32 characters through an index/char interface from the
//   date/time text source and writes them to the display.
//   Sits between the text source (index 0..31 -> ASCII byte) and the LCD pins.
// PARAMETERS
//   PWRUP_CYCLES     2000000  clk cycles to wait after reset before the first command (40 ms @ 50 MHz)
//   EN_CYCLES        25       width of each lcd_e high pulse, in clk cycles
//   CMD_WAIT_CYCLES  2500     hold/wait after lcd_e falls for ordinary commands and data (50 us)
//   CLR_WAIT_CYCLES  100000   wait after lcd_e falls for the Clear command 0x01 (2 ms)
// PORTS
//   clk         in   1  system clock
//   rst         in   1  asynchronous reset, active-high
//   index       out  5  character index requested from the text source (0..31)
//   char_in     in   8  ASCII byte from the source; valid 2 clk edges after index changes
//   lcd_rs      out  1  0 = command, 1 = data
//   lcd_rw      out  1  constant 0 (write only)
//   lcd_e       out  1  LCD enable strobe
//   lcd_data    out  8  LCD data bus
//   init_done   out  1  high from the end of the init sequence until the next reset
//   frame_done  out  1  one-cycle pulse when the last hold of character 31 completes
// BEHAVIOUR
//   Reset values (rst high, asynchronous): index=0, lcd_rs=0, lcd_rw=0, lcd_e=0,
//     lcd_data=0x00, init_done=0, frame_done=0, FSM=PWRUP, all counters=0.
//   States and transitions:
//     PWRUP:    count PWRUP_CYCLES, then go to INIT.
//     INIT:     write commands in order 0x38, 0x38, 0x0C, 0x06, 0x01, all with rs=0.
//               0x01 uses CLR_WAIT_CYCLES for its wait. Then set init_done=1 and go to ADDR.
//     ADDR:     write command 0x80 before index 0 and 0xC0 before index 16, then go to FETCH.
//     FETCH:    index was already updated on FETCH entry. Wait exactly 2 cycles.
//               Latch char_in into lcd_data on the 2nd edge. Set rs=1. Go to the byte write.
//     NEXT:     after the write, if index==15: index<=16, go to ADDR (0xC0).
//               If index==31: index<=0, pulse frame_done, go to ADDR (0x80).
//               Otherwise: index<=index+1, go to FETCH.
//   Byte write sub-sequence, used for every command and data byte:
//     SETUP: 1 cycle, lcd_e=0, rs/data stable.
//     PULSE: EN_CYCLES cycles, lcd_e=1.
//     HOLD:  wait cycles, lcd_e=0.
//     Total = 1 + EN_CYCLES + wait cycles.
//     lcd_rs and lcd_data stay constant from SETUP through the end of HOLD.
//   char_in is sampled only at the FETCH sample edge. Changes to char_in at any
//     other time have no effect on the byte being written.
//   The index counter is 5 bits and wraps 31 -> 0 only through the NEXT rule.
//     No other wrap path exists.
//   Reset mid-operation, including during lcd_e=1: lcd_e drops to 0 immediately
//     (async). After release the FSM restarts at PWRUP with the full init sequence.
//   lcd_e, lcd_rs, lcd_data and index are driven directly from registers (glitch-free).
//   Wait counters are sized for the largest parameter, i.e. $clog2(PWRUP_CYCLES+1) bits.
// TESTING  (bench parameters: PWRUP=10, EN=2, CMD_WAIT=5, CLR_WAIT=20)
//   1. Release reset, hold all inputs
//      -> lcd_e stays 0 for 10 cycles.
//      -> Then lcd_e pulses with data 0x38, 0x38, 0x0C, 0x06, 0x01, each pulse 2 cycles wide, rs=0.
//      -> Rising edges spaced 8 cycles apart, except 23 cycles after 0x01.
//      -> init_done rises after 0x01's wait.
//   2. Model the source as a registered LUT returning 0x40+index
//      -> data pulses appear in order 0x80, 0x40..0x4F, 0xC0, 0x50..0x5F.
//      -> rs=1 on every data pulse only.
//   3. Change char_in to 0xFF during PULSE and HOLD of char 5
//      -> written byte is still 0x45 and lcd_data stays constant until the end of HOLD.
//   4. Let two full frames run
//      -> frame_done pulses exactly once per frame, one cycle wide.
//      -> Next command is 0x80 with index=0; index never exceeds 31.
//   5. Assert rst while lcd_e=1 during char 20
//      -> lcd_e, index and init_done are 0 in the same cycle.
//      -> After release, scenario 1's sequence repeats exactly.
//   6. Check every FETCH
//      -> char_in is sampled exactly 2 edges after index changes.
//      -> Bench source with 1-cycle latency never yields the previous index's byte.

Source files
------------

// File: rtl/lcd_char_writer.sv
`default_nettype none
// ============================================================================
// Module : lcd_char_writer
// Brief  : 16x2 HD44780 8-bit write-only driver: init sequence, then endless
//          refresh of 32 characters fetched by index from a text source.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_char_writer #(
  parameter int PWRUP_CYCLES    = 2000000,
  parameter int EN_CYCLES       = 25,
  parameter int CMD_WAIT_CYCLES = 2500,
  parameter int CLR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] index,
  input  logic [7:0] char_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  // One shared counter must hold the largest interval, whichever parameter that is.
  localparam int MAX_AB = (PWRUP_CYCLES > CLR_WAIT_CYCLES) ? PWRUP_CYCLES : CLR_WAIT_CYCLES;
  localparam int MAX_CD = (EN_CYCLES > CMD_WAIT_CYCLES) ? EN_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(1);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;

  localparam logic [1:0] K_INIT = 2'd0;
  localparam logic [1:0] K_ADDR = 2'd1;
  localparam logic [1:0] K_CHAR = 2'd2;

  localparam logic [2:0] LAST_INIT_STEP = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    kind;
  logic [2:0]    init_step;
  logic          long_wait;
  logic [CW-1:0] hold_last;

  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    case (step)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h38;
      3'd2:    init_cmd = 8'h0C;
      3'd3:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign lcd_rw    = 1'b0;
  assign hold_last = long_wait ? CLR_LAST : CMD_LAST;

  // Every write decision is taken on the last hold edge so consecutive
  // writes chain with no idle cycle between them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_PWRUP;
      cnt        <= '0;
      kind       <= K_INIT;
      init_step  <= 3'd0;
      long_wait  <= 1'b0;
      index      <= 5'd0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt       <= '0;
            kind      <= K_INIT;
            init_step <= 3'd0;
            long_wait <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= init_cmd(3'd0);
            state     <= S_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SETUP: begin
          lcd_e <= 1'b1;
          cnt   <= '0;
          state <= S_PULSE;
        end

        S_PULSE: begin
          if (cnt == EN_LAST) begin
            lcd_e <= 1'b0;
            cnt   <= '0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt == hold_last) begin
            cnt       <= '0;
            long_wait <= 1'b0;
            case (kind)
              K_INIT: begin
                if (init_step == LAST_INIT_STEP) begin
                  init_done <= 1'b1;
                  kind      <= K_ADDR;
                  lcd_rs    <= 1'b0;
                  lcd_data  <= 8'h80;
                end else begin
                  init_step <= init_step + 3'd1;
                  lcd_data  <= init_cmd(init_step + 3'd1);
                  long_wait <= (init_step + 3'd1 == LAST_INIT_STEP);
                end
                state <= S_SETUP;
              end
              K_ADDR: begin
                kind  <= K_CHAR;
                state <= S_FETCH;
              end
              default: begin
                if (index == 5'd15) begin
                  index    <= 5'd16;
                  kind     <= K_ADDR;
                  lcd_rs   <= 1'b0;
                  lcd_data <= 8'hC0;
                  state    <= S_SETUP;
                end else if (index == 5'd31) begin
                  index      <= 5'd0;
                  frame_done <= 1'b1;
                  kind       <= K_ADDR;
                  lcd_rs     <= 1'b0;
                  lcd_data   <= 8'h80;
                  state      <= S_SETUP;
                end else begin
                  index <= index + 5'd1;
                  state <= S_FETCH;
                end
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FETCH: begin
          // Source needs two edges after an index change; sample on the second.
          if (cnt == FETCH_LAST) begin
            cnt       <= '0;
            lcd_data  <= char_in;
            lcd_rs    <= 1'b1;
            long_wait <= 1'b0;
            state     <= S_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_PWRUP;
          cnt   <= '0;
          lcd_e <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_char_writer
// Brief  : Self-checking bench; expected LCD write stream built from the
//          command list, frame layout and write timing rules.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_char_writer;

  localparam int PWRUP = 10;
  localparam int EN    = 2;
  localparam int CMDW  = 5;
  localparam int CLRW  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] index;
  logic [7:0] char_in = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic       init_done, frame_done;

  always #5 clk = ~clk;

  lcd_char_writer #(
    .PWRUP_CYCLES(PWRUP), .EN_CYCLES(EN),
    .CMD_WAIT_CYCLES(CMDW), .CLR_WAIT_CYCLES(CLRW)
  ) dut (
    .clk(clk), .rst(rst), .index(index), .char_in(char_in),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         gap;
    int         wt;
    int         idx;
    bit         last;
  } item_t;

  item_t      q[$];
  item_t      cur;
  logic [7:0] lut [32];
  int         last_wait;
  bit         glitch_on = 1'b0;
  logic [7:0] glitch_val = 8'hFF;
  int         glitch_idx = 5;
  int         frames_seen = 0;

  // Text source: registered lookup, one cycle of latency, with optional corruption.
  always @(posedge clk) char_in <= glitch_on ? glitch_val : lut[index];

  function automatic void push(input logic [7:0] d, input logic rs, input int wt,
                               input int idx, input bit last);
    item_t it;
    it.data = d; it.rs = rs; it.wt = wt; it.idx = idx; it.last = last;
    // Rise-to-rise spacing: setup + pulse + previous wait, plus the 2-cycle fetch for data.
    it.gap  = (last_wait < 0) ? PWRUP + 1 : 1 + EN + last_wait + (rs ? 2 : 0);
    last_wait = wt;
    q.push_back(it);
  endfunction

  function automatic void push_frame();
    push(8'h80, 1'b0, CMDW, 0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) push(8'hC0, 1'b0, CMDW, 16, 1'b0);
      push(lut[i], 1'b1, CMDW, i, i == 31);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    last_wait  = -1;
    glitch_on  = 1'b0;
    glitch_idx = 5;
    glitch_val = 8'hFF;
    for (int i = 0; i < 32; i++) lut[i] = 8'(8'h40 + i);
    push(8'h38, 1'b0, CMDW, 0, 1'b0);
    push(8'h38, 1'b0, CMDW, 0, 1'b0);
    push(8'h0C, 1'b0, CMDW, 0, 1'b0);
    push(8'h06, 1'b0, CMDW, 0, 1'b0);
    push(8'h01, 1'b0, CLRW, 0, 1'b0);
    push_frame();
  endfunction

  int         cyc, rise_cyc, npulse, init_at, fd_at, gap;
  bit         prev_e, in_win;
  logic [7:0] prev_data, held_data;
  logic       prev_rs, held_rs;

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      cyc = 0; rise_cyc = 0; npulse = 0;
      init_at = 1 << 30; fd_at = -1;
      prev_e = 1'b0; in_win = 1'b0;
      prev_data = 8'h00; prev_rs = 1'b0;
    end else begin
      cyc++;
      chk("lcd_rw", lcd_rw, 0);
      chk("frame_done", frame_done, cyc == fd_at);
      chk("init_done", init_done, cyc >= init_at);
      if (glitch_on && index != 5'(glitch_idx)) glitch_on = 1'b0;

      if (lcd_e && !prev_e) begin
        npulse++;
        gap = cyc - rise_cyc;
        if (q.size() == 0) begin
          chk("write_queue_empty", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("rise_gap", gap, cur.gap);
          chk("write_data", lcd_data, cur.data);
          chk("write_rs", lcd_rs, cur.rs);
          chk("write_index", index, cur.idx);
          chk("setup_data", prev_data, lcd_data);
          chk("setup_rs", prev_rs, lcd_rs);
          if (cur.last) fd_at = cyc + EN + cur.wt;
          if (!cur.rs && cur.data == 8'h01) init_at = cyc + EN + cur.wt;
          if (cur.rs && cur.idx == glitch_idx) glitch_on = 1'b1;
          rise_cyc  = cyc;
          in_win    = 1'b1;
          held_data = lcd_data;
          held_rs   = lcd_rs;
        end
        // Hand-derived anchors for the first pass after any reset.
        if (npulse == 1)  chk("first_rise_cycle", cyc, 11);
        if (npulse == 5)  chk("fifth_cmd", lcd_data, 8'h01);
        if (npulse == 6)  begin chk("addr80", lcd_data, 8'h80); chk("gap_after_clear", gap, 23); end
        if (npulse == 7)  begin chk("char0", lcd_data, 8'h40); chk("gap_to_char0", gap, 10); end
        if (npulse == 12) chk("char5_glitched", lcd_data, 8'h45);
        if (npulse == 23) begin chk("addrC0", lcd_data, 8'hC0); chk("gap_to_C0", gap, 8); end
        if (npulse == 24) chk("char16", lcd_data, 8'h50);
      end else if (in_win) begin
        if (cyc < rise_cyc + EN + cur.wt) begin
          chk("hold_data", lcd_data, held_data);
          chk("hold_rs", lcd_rs, held_rs);
          chk("pulse_e", lcd_e, cyc < rise_cyc + EN);
        end else begin
          in_win = 1'b0;
        end
      end

      if (frame_done) begin
        frames_seen++;
        for (int i = 0; i < 32; i++) lut[i] = 8'($urandom);
        glitch_idx = $urandom_range(0, 31);
        glitch_val = 8'($urandom);
        push_frame();
      end
      prev_e    = lcd_e;
      prev_data = lcd_data;
      prev_rs   = lcd_rs;
    end
  end

  initial begin
    bit found;
    int base;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_index", index, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5000 && frames_seen < 2; i++) @(negedge clk);
    chk("two_frames_seen", frames_seen >= 2, 1);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (lcd_e && lcd_rs && index == 5'd20) found = 1'b1;
    end
    chk("char20_pulse_seen", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_e", lcd_e, 0);
    chk("midrst_index", index, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_rs", lcd_rs, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    base = frames_seen;
    for (int i = 0; i < 5000 && frames_seen < base + 1; i++) @(negedge clk);
    chk("frame_after_reset", frames_seen >= base + 1, 1);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
